// File: rtl/gpio_in.sv
// gpio_in: memory-mapped GPIO input peripheral.
// Active-low pins pass through a two-flop synchronizer and a per-pin debounce
// counter. The debounced level is presented inverted (pressed = 1). Selected
// edges set write-1-to-clear pending bits that drive a registered level IRQ.
module gpio_in #(
   parameter int N_PINS          = 4,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic              sys_clk,
   input  logic              sys_reset_n,
   input  logic              wr_en_i,
   input  logic [31:0]       wr_addr_i,
   input  logic [31:0]       wr_data_i,
   input  logic [31:0]       rd_addr_i,
   output logic [31:0]       rd_data_o,
   input  logic [N_PINS-1:0] gpio_in_pins,
   output logic              irq_o
);

   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [3:0] ADDR_IN_DATA  = 4'h0;
   localparam logic [3:0] ADDR_INT_EN   = 4'h4;
   localparam logic [3:0] ADDR_INT_EDGE = 4'h8;
   localparam logic [3:0] ADDR_INT_PEND = 4'hC;

   logic [N_PINS-1:0] sync1_r;
   logic [N_PINS-1:0] sync2_r;
   logic [N_PINS-1:0] stable_r;
   logic [N_PINS-1:0] stable_d_r;
   logic [CNT_W-1:0]  cnt_r [N_PINS];
   logic [N_PINS-1:0] int_en_r;
   logic [N_PINS-1:0] int_edge_r;
   logic [N_PINS-1:0] int_pend_r;
   logic              irq_r;
   logic [3:0]        rd_addr_r;

   logic [N_PINS-1:0] rise_s;
   logic [N_PINS-1:0] fall_s;
   logic [N_PINS-1:0] evt_s;
   logic              we_en_s;
   logic              we_edge_s;
   logic [N_PINS-1:0] pend_clr_s;
   logic [N_PINS-1:0] wr_bits_s;
   logic [31:0]       rd_data_s;

   // Address and data bits above the decoded range are intentionally ignored.
   logic unused_s;
   assign unused_s = ^{wr_addr_i[31:4], rd_addr_i[31:4], wr_data_i[31:N_PINS]};

   assign wr_bits_s = wr_data_i[N_PINS-1:0];

   // Two-flop synchronizer; inversion maps idle-high pins to 0.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         sync1_r <= {N_PINS{1'b0}};
         sync2_r <= {N_PINS{1'b0}};
      end else begin
         sync1_r <= ~gpio_in_pins;
         sync2_r <= sync1_r;
      end
   end

   // Per-pin debounce: accept a new level only after it stays put long enough.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         stable_r <= {N_PINS{1'b0}};
         for (int i = 0; i < N_PINS; i++) begin
            cnt_r[i] <= {CNT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < N_PINS; i++) begin
            if (sync2_r[i] == stable_r[i]) begin
               cnt_r[i] <= {CNT_W{1'b0}};
            end else if (cnt_r[i] == CNT_MAX) begin
               stable_r[i] <= sync2_r[i];
               cnt_r[i]    <= {CNT_W{1'b0}};
            end else begin
               cnt_r[i] <= cnt_r[i] + CNT_W'(1);
            end
         end
      end
   end

   // Delayed debounced level for edge detection.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         stable_d_r <= {N_PINS{1'b0}};
      end else begin
         stable_d_r <= stable_r;
      end
   end

   assign rise_s = stable_r & ~stable_d_r;
   assign fall_s = ~stable_r & stable_d_r;
   assign evt_s  = (int_edge_r & rise_s) | (~int_edge_r & fall_s);

   // Decode bus writes into per-register strobes.
   always_comb begin
      we_en_s    = 1'b0;
      we_edge_s  = 1'b0;
      pend_clr_s = {N_PINS{1'b0}};
      if (wr_en_i) begin
         case (wr_addr_i[3:0])
            ADDR_INT_EN:   we_en_s    = 1'b1;
            ADDR_INT_EDGE: we_edge_s  = 1'b1;
            ADDR_INT_PEND: pend_clr_s = wr_bits_s;
            default: begin
               we_en_s    = 1'b0;
               we_edge_s  = 1'b0;
               pend_clr_s = {N_PINS{1'b0}};
            end
         endcase
      end else begin
         we_en_s    = 1'b0;
         we_edge_s  = 1'b0;
         pend_clr_s = {N_PINS{1'b0}};
      end
   end

   // Control registers; pending bits are W1C and a same-cycle event wins.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         int_en_r   <= {N_PINS{1'b0}};
         int_edge_r <= {N_PINS{1'b0}};
         int_pend_r <= {N_PINS{1'b0}};
      end else begin
         if (we_en_s) begin
            int_en_r <= wr_bits_s;
         end
         if (we_edge_s) begin
            int_edge_r <= wr_bits_s;
         end
         int_pend_r <= (int_pend_r & ~pend_clr_s) | evt_s;
      end
   end

   // Registered level interrupt from enabled pending bits.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= |(int_pend_r & int_en_r);
      end
   end

   // Capture the read address; data follows one cycle later.
   always_ff @(posedge sys_clk or negedge sys_reset_n) begin
      if (!sys_reset_n) begin
         rd_addr_r <= 4'h0;
      end else begin
         rd_addr_r <= rd_addr_i[3:0];
      end
   end

   // Read mux over current register contents, zero-extended to the bus width.
   always_comb begin
      rd_data_s = 32'h0000_0000;
      case (rd_addr_r)
         ADDR_IN_DATA:  rd_data_s = {{(32-N_PINS){1'b0}}, stable_r};
         ADDR_INT_EN:   rd_data_s = {{(32-N_PINS){1'b0}}, int_en_r};
         ADDR_INT_EDGE: rd_data_s = {{(32-N_PINS){1'b0}}, int_edge_r};
         ADDR_INT_PEND: rd_data_s = {{(32-N_PINS){1'b0}}, int_pend_r};
         default:       rd_data_s = 32'h0000_0000;
      endcase
   end

   assign rd_data_o = rd_data_s;
   assign irq_o     = irq_r;

endmodule

// File: doc/gpio_in.md
# gpio_in

Memory-mapped GPIO input peripheral: the receive-side counterpart to the GPIO output block on the same peripheral bus. Samples active-low external input pins (buttons, switches) through a two-flop synchronizer and a per-pin debounce counter. Presents debounced, inverted levels (pressed = 1) as a readable register. Raises a level interrupt on software-selected edges with write-1-to-clear pending bits.

## Interface
- `N_PINS`, 4, number of input pins (1..16).
- `DEBOUNCE_CYCLES`, 250000, consecutive stable cycles required before a level change is accepted (≥2); counter width `$clog2(DEBOUNCE_CYCLES)`.
- `sys_clk`  in  1  single system clock, all logic on the rising edge.
- `sys_reset_n`  in  1  asynchronous, active-low reset.
- `wr_en_i`  in  1  bus write strobe.
- `wr_addr_i`  in  32  write address; only `[3:0]` decoded.
- `wr_data_i`  in  32  write data.
- `rd_addr_i`  in  32  read address; only `[3:0]` decoded.
- `rd_data_o`  out  32  read data for the address registered on the previous edge.
- `gpio_in_pins`  in  `N_PINS`  raw external pins, active-low, asynchronous to `sys_clk`.
- `irq_o`  out  1  registered interrupt, high while any enabled pending bit is set.

## Operation
- **Register map** (`addr[3:0]`). Bits above `N_PINS-1` read 0 and ignore writes.
  - `0x0` `IN_DATA`: RO; debounced level, 1 = pin driven low.
  - `0x4` `INT_EN`: RW; per-pin interrupt enable.
  - `0x8` `INT_EDGE`: RW; per pin, 1 = rising (press), 0 = falling (release).
  - `0xC` `INT_PEND`: RW1C; writing 1 clears a bit, writing 0 has no effect.
  - Any other offset reads 0 and ignores writes.
- **Synchronizer**: `sync1 <= ~gpio_in_pins`, `sync2 <= sync1`. Both reset to 0 (idle-high pins map to 0), so no spurious event is produced at reset release.
- **Debounce** (per pin, independent counter `cnt`):
  - If `sync2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and never reaches `stable`.
- **Edge detect**: `stable_d <= stable`.
  - `rise = stable & ~stable_d`, `fall = ~stable & stable_d`.
  - `evt = INT_EDGE ? rise : fall`, per pin.
- **Pending bits**: `INT_PEND[i]` sets on `evt[i]` regardless of `INT_EN`.
  - A set event and a W1C of the same bit in the same cycle leave the bit **set**; the set wins.
- **Interrupt**: `irq_o <= |(INT_PEND & INT_EN)`.
  - Changing `INT_EN` with a bit already pending asserts or deasserts `irq_o` one cycle later.
- **Read path**: `rd_addr_reg <= rd_addr_i` every cycle. `rd_data_o` is combinational from `rd_addr_reg` and current register contents.
- **Reset values** (all asynchronous on `sys_reset_n` low):
  - Registers, counters, `sync1/2`, `stable`, `stable_d`, `rd_addr_reg` reset to 0.
  - `irq_o` = 0.
  - `rd_data_o` = `IN_DATA` = 0.
  - Reset mid-debounce discards the partial count; no event is generated on release.

## Timing
- Pin change sampled first at edge k:
  - `sync2` updates at k+1.
  - `stable` updates at k+1+`DEBOUNCE_CYCLES`.
  - `INT_PEND` sets at k+2+`DEBOUNCE_CYCLES`.
  - `irq_o` rises at k+3+`DEBOUNCE_CYCLES`.
- Register writes take effect at the edge where `wr_en_i` is high. A W1C of the last enabled pending bit drops `irq_o` one edge later.
- Read latency is one cycle: `rd_data_o` is valid after the edge that captured `rd_addr_i`.
- A pin toggling faster than `DEBOUNCE_CYCLES` never changes `IN_DATA`.
- Events on several pins in the same cycle all set their pending bits.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES=4` and `N_PINS=4`.
- **Reset/idle**: pins = 4'hF, hold `sys_reset_n` low, then release → `IN_DATA`=0, `INT_PEND`=0, `irq_o`=0 for 20 cycles; read of `0x4` returns 0 one cycle after the address is presented.
- **Debounced press**: `INT_EN`=1, `INT_EDGE`=1, pin0 driven 0 at edge k → `IN_DATA`=1 from k+5, `INT_PEND`=1 at k+6, `irq_o`=1 at k+7; write `0xC`=1 → `irq_o`=0 one edge later.
- **Glitch rejection**: pin1 pulsed low for 3 cycles, repeated 5× with 1-cycle gaps → `IN_DATA` stays 0, `INT_PEND` stays 0.
- **Falling edge select**: `INT_EDGE`=0, pin2 pressed then released after 10 cycles → `INT_PEND`=4 only after release; no bit set on press.
- **Set vs. clear collision**: write `0xC`=8 in the same cycle pin3's event fires → `INT_PEND[3]` remains 1; `irq_o` follows `INT_EN[3]`.
- **Reset mid-debounce**: pin0 low for 2 cycles, assert `sys_reset_n` low for 1 cycle, release with pin0 now high → `IN_DATA`=0, no pending bit, `irq_o`=0.
